// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment sweep logic.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } sweep_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int timer_width(input int div);
        return (div > 0) ? $clog2(div + 1) : 1;
    endfunction

endpackage

// File: rtl/seg7_sweep_scheduler_refresh_timer.sv
// Free-running refresh counter; one-cycle tick at terminal count.
module seg7_refresh_timer
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 25000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic o_Tick
);

    localparam int CNT_W = timer_width(REFRESH_DIV);

    generate
        if (REFRESH_DIV == 0) begin : g_off
            assign o_Tick = 1'b0;
        end else begin : g_cnt
            localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TERM) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign o_Tick = (cnt_q == TERM);
        end
    endgenerate

endmodule

// File: rtl/seg7_sweep_scheduler.sv
// Shares one external nibble-to-segment converter across all digits and
// latches each result into glitch-free active-low segment registers.
module seg7_sweep_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int CONV_LATENCY = 1,
    parameter int REFRESH_DIV  = 25000,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [4*NUM_DIGITS-1:0] i_Digits,
    input  logic [NUM_DIGITS-1:0]   i_Blank_Mask,
    input  logic                    i_Update,
    output logic [3:0]              o_Conv_Nibble,
    input  logic [6:0]              i_Conv_Seg,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Busy,
    output logic                    o_Done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [1:0] WAIT_LAST = 2'(CONV_LATENCY - 2);

    sweep_state_e            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d, blank_new;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [3:0]              nib_q, nib_d;
    logic [1:0]              wcnt_q, wcnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    logic                    tick;
    logic                    trigger;
    logic                    lz;

    seg7_refresh_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .o_Tick(tick)
    );

    assign trigger = i_Update | tick;
    assign idx_nxt = idx_q + 1'b1;

    // Only evaluated at snapshot time, so it reflects the snapshot exactly.
    always_comb begin
        blank_new = i_Blank_Mask;
        lz = (LZ_SUPPRESS != 0);
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz = lz && (i_Digits[4*k +: 4] == 4'h0);
            if (lz) begin
                blank_new[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        blank_d = blank_q;
        seg_d   = seg_q;
        nib_d   = nib_q;
        wcnt_d  = wcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pend_d  = pend_q;
        if (state_q != ST_IDLE && trigger) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (trigger || pend_q) begin
                    state_d = ST_ISSUE;
                    snap_d  = i_Digits;
                    blank_d = blank_new;
                    idx_d   = '0;
                    nib_d   = i_Digits[3:0];
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                wcnt_d  = '0;
                state_d = (CONV_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                seg_d[7*int'(idx_q) +: 7] =
                    blank_q[idx_q] ? SEG_BLANK : ~i_Conv_Seg;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_nxt;
                    nib_d   = snap_q[4*int'(idx_nxt) +: 4];
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            blank_q <= '0;
            seg_q   <= '1;
            nib_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            nib_q   <= nib_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign o_Conv_Nibble = nib_q;
    assign o_Segments    = seg_q;
    assign o_Busy        = busy_q;
    assign o_Done        = done_q;

endmodule

// File: tb/tb_seg7_sweep_scheduler.sv
// Directed bench: one-latency manual-sweep instance plus a
// three-latency auto-refresh instance, each fed by a converter model.
module tb_seg7_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dig_a;
    logic [1:0]  mask_a;
    logic        upd_a;
    logic [3:0]  nib_a;
    logic [6:0]  conv_a;
    logic [13:0] seg_a;
    logic        busy_a, done_a;

    logic [7:0]  dig_b  = 8'h42;
    logic [1:0]  mask_b = 2'b00;
    logic        upd_b  = 1'b0;
    logic [3:0]  nib_b;
    logic [6:0]  pb [3];
    logic [13:0] seg_b;
    logic        busy_b, done_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int bc;

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) conv_a <= hex7(nib_a);

    always_ff @(posedge clk) begin
        pb[0] <= hex7(nib_b);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    seg7_sweep_scheduler #(
        .NUM_DIGITS(2), .CONV_LATENCY(1),
        .REFRESH_DIV(0), .LZ_SUPPRESS(1)
    ) dut_a (
        .i_Clk(clk), .i_Rst(rst),
        .i_Digits(dig_a), .i_Blank_Mask(mask_a),
        .i_Update(upd_a), .o_Conv_Nibble(nib_a),
        .i_Conv_Seg(conv_a), .o_Segments(seg_a),
        .o_Busy(busy_a), .o_Done(done_a)
    );

    seg7_sweep_scheduler #(
        .NUM_DIGITS(2), .CONV_LATENCY(3),
        .REFRESH_DIV(10), .LZ_SUPPRESS(1)
    ) dut_b (
        .i_Clk(clk), .i_Rst(rst),
        .i_Digits(dig_b), .i_Blank_Mask(mask_b),
        .i_Update(upd_b), .o_Conv_Nibble(nib_b),
        .i_Conv_Seg(pb[2]), .o_Segments(seg_b),
        .o_Busy(busy_b), .o_Done(done_b)
    );

    task automatic expect_eq(input string tag,
                             input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic pulse_a();
        upd_a = 1'b1;
        @(negedge clk);
        upd_a = 1'b0;
    endtask

    task automatic wait_done_a(output int c);
        c = 0;
        while (!done_a && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        dig_a  = 8'h00;
        mask_a = 2'b00;
        upd_a  = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("rst_seg_a", seg_a, 14'h3FFF);
        expect_eq("rst_busy_a", busy_a, 0);
        expect_eq("rst_done_a", done_a, 0);
        expect_eq("rst_nib_a", nib_a, 0);
        expect_eq("rst_seg_b", seg_b, 14'h3FFF);
        rst = 1'b0;
        @(negedge clk);

        dig_a = 8'h42;
        pulse_a();
        expect_eq("busy_start", busy_a, 1);
        wait_done_a(cyc);
        expect_eq("sweep_len", cyc, 4);
        expect_eq("seg_42", seg_a, 14'h0CA4);
        expect_eq("busy_end", busy_a, 0);
        @(negedge clk);
        expect_eq("done_once", done_a, 0);

        dig_a = 8'h07;
        pulse_a();
        wait_done_a(cyc);
        expect_eq("seg_07_lz", seg_a, 14'h3FF8);

        dig_a = 8'h00;
        pulse_a();
        wait_done_a(cyc);
        expect_eq("seg_00_lz", seg_a, 14'h3FC0);

        mask_a = 2'b01;
        dig_a  = 8'h35;
        pulse_a();
        wait_done_a(cyc);
        expect_eq("seg_mask", seg_a, 14'h187F);
        mask_a = 2'b00;
        @(negedge clk);

        dig_a = 8'h35;
        pulse_a();
        @(negedge clk);
        dig_a = 8'hAB;
        upd_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        upd_a = 1'b0;
        wait_done_a(cyc);
        expect_eq("pend_first_len", cyc, 1);
        expect_eq("pend_first_seg", seg_a, 14'h1812);
        @(negedge clk);
        expect_eq("pend_restart", busy_a, 1);
        wait_done_a(cyc);
        expect_eq("pend_second_len", cyc, 4);
        expect_eq("pend_second_seg", seg_a, 14'h0403);
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bc += int'(done_a) + int'(busy_a);
        end
        expect_eq("pend_no_third", bc, 0);

        cyc = 0;
        while (!done_b && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        expect_eq("auto_first", done_b, 1);
        cyc = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            bc += int'(busy_b);
        end while (!done_b && cyc < 40);
        expect_eq("auto_period", cyc, 10);
        expect_eq("auto_busy_len", bc, 8);
        expect_eq("auto_seg", seg_b, 14'h0CA4);

        cyc = 0;
        while (!busy_b && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        expect_eq("wait_nib", nib_b, 4'h2);
        expect_eq("wait_busy", busy_b, 1);
        #2 rst = 1'b1;
        #1;
        expect_eq("arst_seg_b", seg_b, 14'h3FFF);
        expect_eq("arst_busy_b", busy_b, 0);
        expect_eq("arst_done_b", done_b, 0);
        expect_eq("arst_nib_b", nib_b, 0);
        expect_eq("arst_seg_a", seg_a, 14'h3FFF);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("post_rst_busy_b", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
